// File: rtl/ram40_pkg.sv
// Shared constants and helpers for the 4 Kbit block RAM model.
// Aspect-ratio modes, row geometry and per-mode width/address-bit functions.
package ram40_pkg;

    localparam int unsigned MODE_256X16 = 0;
    localparam int unsigned MODE_512X8  = 1;
    localparam int unsigned MODE_1024X4 = 2;
    localparam int unsigned MODE_2048X2 = 3;

    localparam int unsigned DEPTH_ROWS = 256;
    localparam int unsigned ROW_W      = 16;

    // Data width seen at a port configured for the given mode.
    function automatic int unsigned width_of(int unsigned mode);
        return ROW_W >> mode;
    endfunction

    // Number of meaningful address bits for the given mode.
    function automatic int unsigned abits_of(int unsigned mode);
        return 8 + mode;
    endfunction

endpackage

// File: rtl/ram40_lane.sv
// Combinational lane access into a 16-bit row: extracts a W-bit lane (INSERT=0)
// or merges write data into the row (INSERT=1), with a per-bit mask in mode 0.
module ram40_lane
    import ram40_pkg::*;
#(
    parameter int unsigned MODE   = MODE_256X16,
    parameter bit          INSERT = 1'b0
) (
    input  logic [15:0] row_i,
    input  logic [2:0]  lane_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] mask_i,
    output logic [15:0] data_o
);

    localparam int unsigned W        = width_of(MODE);
    localparam logic [15:0] LaneMask = 16'((32'd1 << W) - 32'd1);
    localparam logic [2:0]  LaneSel  = 3'((32'd1 << MODE) - 32'd1);

    logic [4:0]  shamt;
    logic [15:0] field_mask;
    logic [15:0] wr_mask;
    logic [15:0] extracted;
    logic [15:0] inserted;

    always_comb begin
        shamt      = 5'(32'(lane_i & LaneSel) * W);
        field_mask = LaneMask << shamt;
        extracted  = (row_i >> shamt) & LaneMask;
        // Only the full-width mode honours the bit mask; narrower modes write the whole lane.
        wr_mask    = (MODE == MODE_256X16) ? ~mask_i : field_mask;
        inserted   = (row_i & ~wr_mask) | (((wdata_i & LaneMask) << shamt) & wr_mask);
        data_o     = INSERT ? inserted : extracted;
    end

endmodule

// File: rtl/ram40_4k.sv
// 4 Kbit block RAM: 256 rows x 16 bits, one write port and one registered read port
// on a single clock, with independently selectable read and write aspect ratios.
module ram40_4k
    import ram40_pkg::*;
#(
    parameter int unsigned READ_MODE  = MODE_256X16,
    parameter int unsigned WRITE_MODE = MODE_256X16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [10:0] waddr_i,
    input  logic [10:0] raddr_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] mask_i,
    input  logic        we_i,
    input  logic        wclke_i,
    input  logic        re_i,
    input  logic        rclke_i,
    output logic [15:0] rdata_o
);

    localparam logic [10:0] WAddrMask = 11'((32'd1 << abits_of(WRITE_MODE)) - 32'd1);
    localparam logic [10:0] RAddrMask = 11'((32'd1 << abits_of(READ_MODE)) - 32'd1);
    localparam logic [10:0] WLaneMask = 11'((32'd1 << WRITE_MODE) - 32'd1);
    localparam logic [10:0] RLaneMask = 11'((32'd1 << READ_MODE) - 32'd1);

    // Power-up contents are zero; reset never touches the array.
    logic [15:0] mem_q [DEPTH_ROWS] = '{default: '0};

    logic [7:0]  wrow;
    logic [7:0]  rrow;
    logic [2:0]  wlane;
    logic [2:0]  rlane;
    logic [15:0] wrow_old;
    logic [15:0] wrow_new;
    logic [15:0] rrow_data;
    logic [15:0] rd_lane;
    logic [15:0] rdata_q;
    logic        wr_en;
    logic        rd_en;

    always_comb begin
        wrow      = 8'((waddr_i & WAddrMask) >> WRITE_MODE);
        rrow      = 8'((raddr_i & RAddrMask) >> READ_MODE);
        wlane     = 3'(waddr_i & WLaneMask);
        rlane     = 3'(raddr_i & RLaneMask);
        wrow_old  = mem_q[wrow];
        rrow_data = mem_q[rrow];
        wr_en     = we_i & wclke_i;
        rd_en     = re_i & rclke_i;
    end

    ram40_lane #(
        .MODE   (WRITE_MODE),
        .INSERT (1'b1)
    ) u_wr_lane (
        .row_i   (wrow_old),
        .lane_i  (wlane),
        .wdata_i (wdata_i),
        .mask_i  (mask_i),
        .data_o  (wrow_new)
    );

    ram40_lane #(
        .MODE   (READ_MODE),
        .INSERT (1'b0)
    ) u_rd_lane (
        .row_i   (rrow_data),
        .lane_i  (rlane),
        .wdata_i (16'h0000),
        .mask_i  (16'h0000),
        .data_o  (rd_lane)
    );

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wrow] <= wrow_new;
        end
    end

    // Read samples the array before the same-edge write lands, giving read-old-data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= 16'h0000;
        end else if (rd_en) begin
            rdata_q <= rd_lane;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_ram40_4k.sv
// Scoreboard bench for ram40_4k: three instances with different aspect ratios share
// one stimulus stream and are checked against a flat bit-array reference model.
module tb_ram40_4k;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] waddr = '0;
    logic [10:0] raddr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] mask = '0;
    logic        we = 1'b0;
    logic        wclke = 1'b0;
    logic        re = 1'b0;
    logic        rclke = 1'b0;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic [15:0] rdata2;

    int n_checks = 0;
    int n_pass = 0;

    logic [4095:0] m0 = '0;
    logic [4095:0] m1 = '0;
    logic [4095:0] m2 = '0;
    logic [15:0]   h0 = '0;
    logic [15:0]   h1 = '0;
    logic [15:0]   h2 = '0;
    logic [15:0]   q0[$];
    logic [15:0]   q1[$];
    logic [15:0]   q2[$];

    always #5 clk = ~clk;

    ram40_4k #(.READ_MODE(0), .WRITE_MODE(0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .waddr_i(waddr), .raddr_i(raddr), .wdata_i(wdata),
        .mask_i(mask), .we_i(we), .wclke_i(wclke), .re_i(re), .rclke_i(rclke),
        .rdata_o(rdata0)
    );

    ram40_4k #(.READ_MODE(0), .WRITE_MODE(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .waddr_i(waddr), .raddr_i(raddr), .wdata_i(wdata),
        .mask_i(mask), .we_i(we), .wclke_i(wclke), .re_i(re), .rclke_i(rclke),
        .rdata_o(rdata1)
    );

    ram40_4k #(.READ_MODE(2), .WRITE_MODE(3)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .waddr_i(waddr), .raddr_i(raddr), .wdata_i(wdata),
        .mask_i(mask), .we_i(we), .wclke_i(wclke), .re_i(re), .rclke_i(rclke),
        .rdata_o(rdata2)
    );

    // The RAM is a flat 4096-bit string; word a of width w occupies bits [a*w +: w].
    function automatic logic [15:0] mread(logic [4095:0] m, int mode, logic [10:0] addr);
        int w = 16 >> mode;
        int a = int'(addr) % (256 << mode);
        logic [15:0] r = '0;
        for (int i = 0; i < w; i++) r[i] = m[a * w + i];
        return r;
    endfunction

    function automatic logic [4095:0] mwrite(logic [4095:0] m, int mode, logic [10:0] addr,
                                             logic [15:0] d, logic [15:0] mk);
        int w = 16 >> mode;
        int a = int'(addr) % (256 << mode);
        for (int i = 0; i < w; i++) begin
            if (mode != 0 || !mk[i]) m[a * w + i] = d[i];
        end
        return m;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: issue side of the scoreboard, one expectation per clock edge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (re && rclke) begin
                h0 = mread(m0, 0, raddr);
                h1 = mread(m1, 0, raddr);
                h2 = mread(m2, 2, raddr);
            end
        end else begin
            h0 = '0;
            h1 = '0;
            h2 = '0;
        end
        if (we && wclke) begin
            m0 = mwrite(m0, 0, waddr, wdata, mask);
            m1 = mwrite(m1, 1, waddr, wdata, mask);
            m2 = mwrite(m2, 3, waddr, wdata, mask);
        end
        q0.push_back(h0);
        q1.push_back(h1);
        q2.push_back(h2);
    end

    // Monitor: compares the registered output mid-cycle against the queued expectation.
    always @(negedge clk) begin
        logic [15:0] e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("sb dut0 rdata", rdata0, rst_n ? e : 16'h0000);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("sb dut1 rdata", rdata1, rst_n ? e : 16'h0000);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check("sb dut2 rdata", rdata2, rst_n ? e : 16'h0000);
        end
    end

    task automatic cyc(bit w, bit wc, logic [10:0] wa, logic [15:0] wd, logic [15:0] mk,
                       bit r, bit rc, logic [10:0] ra);
        we = w;
        wclke = wc;
        waddr = wa;
        wdata = wd;
        mask = mk;
        re = r;
        rclke = rc;
        raddr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [10:0] a, logic [15:0] d, logic [15:0] mk);
        cyc(1'b1, 1'b1, a, d, mk, 1'b0, 1'b0, 11'd0);
    endtask

    task automatic rd(logic [10:0] a);
        cyc(1'b0, 1'b0, 11'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, a);
    endtask

    initial begin
        #1;
        check("reset rdata", rdata0, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        wr(11'd3, 16'h0AFE, 16'h0000);
        wr(11'd2, 16'h0800, 16'h0000);
        rd(11'd3);
        check("mode0 read addr3", rdata0, 16'h0AFE);
        rd(11'd2);
        check("mode0 read addr2", rdata0, 16'h0800);

        wr(11'd5, 16'h1234, 16'h0000);
        wr(11'd5, 16'hFFFF, 16'hFF00);
        rd(11'd5);
        check("mask low byte", rdata0, 16'h12FF);
        wr(11'd5, 16'h0000, 16'h00FF);
        rd(11'd5);
        check("mask high byte", rdata0, 16'h00FF);

        cyc(1'b1, 1'b0, 11'd7, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 11'd0);
        rd(11'd3);
        check("reread addr3", rdata0, 16'h0AFE);
        cyc(1'b0, 1'b0, 11'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 11'd7);
        check("rclke low holds", rdata0, 16'h0AFE);
        rd(11'd7);
        check("wclke low no write", rdata0, 16'h0000);

        wr(11'd9, 16'h00C5, 16'h0000);
        cyc(1'b1, 1'b1, 11'd9, 16'h0EE7, 16'h0000, 1'b1, 1'b1, 11'd9);
        check("same-cycle old data", rdata0, 16'h00C5);
        rd(11'd9);
        check("same-cycle new data", rdata0, 16'h0EE7);

        wr(11'd4, 16'h0FFF, 16'h0000);
        rd(11'd4);
        check("preload addr4", rdata0, 16'h0FFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset clears", rdata0, 16'h0000);
        cyc(1'b1, 1'b1, 11'd6, 16'h1111, 16'h0000, 1'b1, 1'b1, 11'd4);
        check("read ignored in reset", rdata0, 16'h0000);
        rst_n = 1'b1;
        rd(11'd4);
        check("memory kept over reset", rdata0, 16'h0FFF);
        rd(11'd6);
        check("write during reset", rdata0, 16'h1111);

        wr(11'd0, 16'h00AB, 16'h0000);
        wr(11'd1, 16'h00CD, 16'h0000);
        rd(11'd0);
        check("w8 r16 alias", rdata1, 16'hCDAB);
        rd(11'd2047);
        check("upper addr wrap", rdata0, mread(m0, 0, 11'd255));

        for (int i = 0; i < 3000; i++) begin
            logic [10:0] wa;
            logic [10:0] ra;
            rst_n = ($urandom_range(0, 63) != 0);
            wa = ($urandom_range(0, 1) != 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
            ra = ($urandom_range(0, 1) != 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, wa, 16'($urandom),
                16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ra);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 11'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 11'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
